bk_adder_pipe: RTL and testbench

Parametrised, pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface. It is the clocked successor of the fixed 12-bit combinational Brent-Kung adder. It generalises operand width, adds carry-in, subtract mode and signed-overflow flagging, and adds configurable pipeline depth with full backpressure. It sits between operand-producing datapath stages and result consumers wherever a registered, throughput-1 adder is needed.

---
 rtl/bk_adder_pipe.sv | 157 +++++++++++++++
 tb/tb_bk_adder_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bk_adder_pipe
// Purpose  : Pipelined Brent-Kung prefix adder/subtractor, valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module bk_adder_pipe #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   // Prefix nodes: index 0 is the carry-in, index i+1 is operand bit i.
   localparam int c_nodes  = WIDTH + 1;
   localparam int c_log    = $clog2(c_nodes);
   localparam int c_levels = 2 * c_log - 1;
   localparam int c_gpw    = 2 * c_nodes;
   localparam int c_payw   = c_gpw + WIDTH;

   // Last prefix level completed before the register of a given rank.
   function automatic int level_end(input int rank);
      if (rank == 0)
         return 0;
      if (STAGES == 1)
         return c_levels;
      return ((rank - 1) * c_levels) / (STAGES - 1);
   endfunction

   // Levels 1..c_log are the up-sweep, the remainder the down-sweep.
   function automatic logic [c_gpw-1:0] apply_level(input logic [c_gpw-1:0] gp,
                                                    input int lvl);
      logic [c_nodes-1:0] g, p, g_n, p_n;
      int   span;
      logic up;
      {g, p} = gp;
      g_n    = g;
      p_n    = p;
      up     = (lvl <= c_log);
      span   = up ? (1 << (lvl - 1)) : (1 << (2 * c_log - 1 - lvl));
      for (int i = 0; i < c_nodes; i++) begin
         if (up ? (((i + 1) & (2 * span - 1)) == 0)
                : ((((i + 1) & (2 * span - 1)) == span) && (i >= 2 * span))) begin
            g_n[i] = g[i] | (p[i] & g[i - span]);
            p_n[i] = p[i] & p[i - span];
         end
      end
      return {g_n, p_n};
   endfunction

   logic [WIDTH-1:0]  w_bx;
   logic [WIDTH-1:0]  w_hp;
   logic              w_c0;
   logic [STAGES-1:0] w_vld;
   logic [STAGES-1:0] w_vin;
   logic [STAGES-1:0] w_load;
   logic [c_payw-1:0] w_src [STAGES];
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_ovf;

   always_comb begin
      w_bx = in_sub ? ~in_b : in_b;
      w_c0 = in_sub ? ~in_cin : in_cin;
      w_hp = in_a ^ w_bx;
   end

   // Payload layout: {half-sums, generate[nodes], propagate[nodes]}.
   assign w_src[0] = {w_hp, in_a & w_bx, w_c0, w_hp, 1'b0};

   always_comb begin
      w_load           = '0;
      w_vin            = '0;
      w_load[STAGES-1] = out_ready | ~w_vld[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--)
         w_load[k] = ~w_vld[k] | w_load[k+1];
      w_vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++)
         w_vin[k] = w_vld[k-1];
   end

   assign in_ready = w_load[0];

   for (genvar r = 0; r < STAGES; r++) begin : g_rank
      localparam int c_lo = level_end(r) + 1;
      localparam int c_hi = level_end(r + 1);

      logic [c_gpw-1:0] w_gp;
      logic [WIDTH-1:0] w_hp_r;

      always_comb begin
         w_gp = w_src[r][c_gpw-1:0];
         for (int lv = c_lo; lv <= c_hi; lv++)
            w_gp = apply_level(w_gp, lv);
      end

      assign w_hp_r = w_src[r][c_payw-1:c_gpw];

      if (r < STAGES - 1) begin : g_mid
         logic              r_vld;
         logic [c_payw-1:0] r_pay;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_pay <= '0;
            end else if (w_load[r]) begin
               r_vld <= w_vin[r];
               r_pay <= {w_hp_r, w_gp};
            end
         end

         assign w_vld[r]   = r_vld;
         assign w_src[r+1] = r_pay;
      end else begin : g_last
         logic               r_vld;
         logic [c_nodes-1:0] w_c;

         // After the full tree, generate at node i is the carry into bit i.
         assign w_c = w_gp[c_gpw-1:c_nodes];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld  <= 1'b0;
               r_sum  <= '0;
               r_cout <= 1'b0;
               r_ovf  <= 1'b0;
            end else if (w_load[r]) begin
               r_vld  <= w_vin[r];
               r_sum  <= w_hp_r ^ w_c[WIDTH-1:0];
               r_cout <= w_c[WIDTH];
               r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
            end
         end

         assign w_vld[r] = r_vld;
      end
   end

   assign out_valid = w_vld[STAGES-1];
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_adder_pipe
// Purpose  : Self-checking bench for bk_adder_pipe (vectors + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_bk_adder_pipe;

   typedef struct {
      string       name;
      logic [11:0] a;
      logic [11:0] b;
      logic        cin;
      logic        sub;
      logic [11:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        sweep_rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_a;
   logic [11:0] in_b;
   logic        in_cin;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   int          checks;
   int          failures;
   int          sweep_done;
   logic [65:0] sbq[$];
   logic        m_acc;
   logic        m_pop;

   bk_adder_pipe #(.WIDTH(12), .STAGES(2)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_ovf  (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain binary arithmetic, result packed as {cout, ovf, sum}.
   function automatic logic [65:0] model(input int w, input logic [63:0] a, b,
                                         input logic cin, sub);
      logic [63:0] mask, am, bm;
      logic [64:0] t;
      logic        c0, ovf;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bm   = (sub ? ~b : b) & mask;
      c0   = sub ? ~cin : cin;
      t    = {1'b0, am} + {1'b0, bm} + {64'd0, c0};
      ovf  = (am[w-1] == bm[w-1]) && (t[w-1] != am[w-1]);
      return {t[w], ovf, t[63:0] & mask};
   endfunction

   function automatic logic [65:0] pack(input logic co, of, input logic [63:0] s);
      return {co, of, s};
   endfunction

   function automatic vec_t mk(input string n, input logic [11:0] a, b,
                               input logic ci, sb, input logic [11:0] s,
                               input logic co, of);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.cin = ci; v.sub = sb;
      v.sum = s; v.cout = co; v.ovf = of;
      return v;
   endfunction

   task automatic check(input string name, input logic [65:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One cycle on the main DUT: drive at negedge, observe the transfers of the next edge.
   task automatic drive_cycle(input logic v, input logic [11:0] a, b,
                              input logic ci, sb, ordy);
      logic [65:0] e;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_cin = ci; in_sub = sb; out_ready = ordy;
      #1;
      m_acc = in_valid && in_ready;
      m_pop = out_valid && out_ready;
      if (m_pop) begin
         check("sb output expected", 66'(sbq.size() != 0), 66'(1));
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb result", pack(out_cout, out_ovf, 64'(out_sum)), e);
         end
      end
      if (m_acc)
         sbq.push_back(model(12, 64'(in_a), 64'(in_b), in_cin, in_sub));
   endtask

   task automatic apply_vec(input vec_t v);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
      out_ready = 1'b1;
      #1;
      check({v.name, " in_ready"}, 66'(in_ready), 66'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({v.name, " latency"}, 66'(lat), 66'(2));
      check({v.name, " result"}, pack(out_cout, out_ovf, 64'(out_sum)),
            pack(v.cout, v.ovf, 64'(v.sum)));
      @(posedge clk);
   endtask

   initial begin
      vec_t        vecs[7];
      int          recv, gaps, ir_low, acc, popped;
      logic        got_first, have_held;
      logic [65:0] held;
      logic [11:0] ba, bb;
      logic        bc, bs;

      checks     = 0;
      failures   = 0;
      sweep_done = 0;
      vecs[0] = mk("add FFF+001",     12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      vecs[1] = mk("sub 000-001",     12'h000, 12'h001, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0);
      vecs[2] = mk("sub 800-001",     12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
      vecs[3] = mk("add 7FF+001",     12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
      vecs[4] = mk("add 123+456+1",   12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0);
      vecs[5] = mk("sub 005-003-1",   12'h005, 12'h003, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0);
      vecs[6] = mk("add 800+800",     12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

      // Reset with a beat offered: nothing captured, outputs cleared.
      rst_n = 1'b0; sweep_rst_n = 1'b0;
      in_valid = 1'b1; in_a = 12'h111; in_b = 12'h222; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b0;
      #2;
      check("reset out_valid", 66'(out_valid), 66'(0));
      check("reset result", pack(out_cout, out_ovf, 64'(out_sum)), 66'(0));
      check("reset in_ready", 66'(in_ready), 66'(1));
      #10;
      rst_n = 1'b1; sweep_rst_n = 1'b1; in_valid = 1'b0;
      #7;
      check("post-reset no stale beat", 66'(out_valid), 66'(0));

      foreach (vecs[i])
         apply_vec(vecs[i]);

      // Back-to-back streaming with the consumer always ready.
      recv = 0; gaps = 0; ir_low = 0; got_first = 1'b0;
      for (int i = 0; i < 200; i++) begin
         drive_cycle(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         if (!in_ready) ir_low++;
         if (m_pop) recv++;
         if (got_first && !out_valid) gaps++;
         if (out_valid) got_first = 1'b1;
      end
      for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
         drive_cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
         if (m_pop) recv++;
         if (!out_valid) gaps++;
      end
      check("stream in_ready low cycles", 66'(ir_low), 66'(0));
      check("stream results", 66'(recv), 66'(200));
      check("stream gaps", 66'(gaps), 66'(0));
      check("stream queue empty", 66'(sbq.size()), 66'(0));

      // Backpressure: consumer stalled for 6 cycles.
      acc = 0; have_held = 1'b0; held = '0;
      ba = 12'($urandom); bb = 12'($urandom); bc = 1'($urandom); bs = 1'($urandom);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, ba, bb, bc, bs, 1'b0);
         if (m_acc) begin
            acc++;
            ba = 12'($urandom); bb = 12'($urandom); bc = 1'($urandom); bs = 1'($urandom);
         end
         if (out_valid) begin
            if (have_held)
               check("stall output stable", pack(out_cout, out_ovf, 64'(out_sum)), held);
            held      = pack(out_cout, out_ovf, 64'(out_sum));
            have_held = 1'b1;
         end
      end
      check("bp beats accepted", 66'(acc), 66'(2));
      check("bp in_ready when full", 66'(in_ready), 66'(0));
      popped = 0;
      for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
         drive_cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
         if (m_pop) popped++;
      end
      check("bp drained beats", 66'(popped), 66'(2));

      // Asynchronous reset with two beats in flight.
      drive_cycle(1'b1, 12'h0AA, 12'h055, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b1, 12'h0F0, 12'h00F, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("in-flight before reset", 66'(out_valid), 66'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 66'(out_valid), 66'(0));
      check("async reset result", pack(out_cout, out_ovf, 64'(out_sum)), 66'(0));
      #1;
      rst_n = 1'b1;
      sbq.delete();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
         check("no stale beat after reset", 66'(out_valid), 66'(0));
      end
      apply_vec(vecs[4]);

      for (int t = 0; t < 60000 && sweep_done < 8; t++)
         @(posedge clk);
      check("parameter sweep completed", 66'(sweep_done), 66'(8));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Parameter sweep: WIDTH in {2,12,32,64} x STAGES in {1,4}, random backpressure.
   for (genvar ci = 0; ci < 8; ci++) begin : g_sweep
      localparam int SW = (ci % 4 == 0) ? 2 : (ci % 4 == 1) ? 12 : (ci % 4 == 2) ? 32 : 64;
      localparam int SS = (ci < 4) ? 1 : 4;
      localparam int NB = (SW == 2) ? 600 : 10000;

      logic          s_iv, s_ir, s_ci, s_sb, s_ov, s_or, s_co, s_of;
      logic [SW-1:0] s_a, s_b, s_sum;
      logic [65:0]   s_q[$];

      bk_adder_pipe #(.WIDTH(SW), .STAGES(SS)) u_sweep (
         .clk      (clk),
         .rst_n    (sweep_rst_n),
         .in_valid (s_iv),
         .in_ready (s_ir),
         .in_a     (s_a),
         .in_b     (s_b),
         .in_cin   (s_ci),
         .in_sub   (s_sb),
         .out_valid(s_ov),
         .out_ready(s_or),
         .out_sum  (s_sum),
         .out_cout (s_co),
         .out_ovf  (s_of)
      );

      initial begin
         int          sent, got, cyc, lat;
         logic [63:0] ra, rb;
         logic [65:0] e;
         string       tag;
         tag  = $sformatf("sweep W%0d S%0d", SW, SS);
         s_iv = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sb = 1'b0; s_or = 1'b0;
         while (!sweep_rst_n) @(negedge clk);

         @(negedge clk);
         s_iv = 1'b1; s_a = SW'(1); s_b = SW'(1); s_or = 1'b1;
         @(posedge clk);
         #1;
         s_iv = 1'b0;
         lat  = 1;
         while (!s_ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check({tag, " latency"}, 66'(lat), 66'(SS));
         check({tag, " probe"}, pack(s_co, s_of, 64'(s_sum)), model(SW, 64'd1, 64'd1, 1'b0, 1'b0));
         @(posedge clk);

         sent = 0; got = 0; cyc = 0;
         while (got < NB && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (sent < NB && $urandom_range(3) != 0) begin
               s_iv = 1'b1;
               if (SW == 2 && sent < 64) begin
                  ra   = 64'(sent % 4);
                  rb   = 64'((sent / 4) % 4);
                  s_ci = 1'((sent / 16) % 2);
                  s_sb = 1'((sent / 32) % 2);
               end else begin
                  ra   = {$urandom, $urandom};
                  rb   = {$urandom, $urandom};
                  s_ci = 1'($urandom);
                  s_sb = 1'($urandom);
               end
               s_a = ra[SW-1:0];
               s_b = rb[SW-1:0];
            end else begin
               s_iv = 1'b0;
            end
            s_or = ($urandom_range(9) < 7);
            #1;
            if (s_ov && s_or) begin
               check({tag, " output expected"}, 66'(s_q.size() != 0), 66'(1));
               if (s_q.size() != 0) begin
                  e = s_q.pop_front();
                  check({tag, " result"}, pack(s_co, s_of, 64'(s_sum)), e);
                  got++;
               end
            end
            if (s_iv && s_ir) begin
               s_q.push_back(model(SW, 64'(s_a), 64'(s_b), s_ci, s_sb));
               sent++;
            end
         end
         check({tag, " beats received"}, 66'(got), 66'(NB));
         check({tag, " queue empty"}, 66'(s_q.size()), 66'(0));
         s_iv = 1'b0;
         sweep_done++;
      end
   end

endmodule
`default_nettype wire
